// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes big-endian into a 32-bit word and keeps the running XOR
// of every data byte in the current load.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic [7:0]        xor_acc,
  output logic              last_byte
);

  logic [1:0] byte_idx;

  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

  // Shifting left leaves the first byte of each group of four in the MSB lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word     <= '0;
      xor_acc  <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      xor_acc  <= '0;
      byte_idx <= '0;
    end else if (byte_en) begin
      word     <= {word[WORD_W-9:0], byte_in};
      xor_acc  <= xor_acc ^ byte_in;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory from address 0, verifies an XOR
// checksum and holds the datapath in reset until a load succeeds.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  state_t          state_nx;
  logic [ADDR_W:0] words_left;
  logic [7:0]      xor_acc;
  logic            last_byte;
  logic            byte_fire;
  logic            start_ok;

  assign byte_fire = byte_valid & byte_ready;
  assign start_ok  = start && (state == IDLE);

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .byte_en   (byte_fire && (state == RECV)),
    .byte_in   (byte_data),
    .word      (imem_wdata),
    .xor_acc   (xor_acc),
    .last_byte (last_byte)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)
                 state_nx = (len_words == '0 || len_words > DEPTH) ? DONE : RECV;
      RECV:    if (byte_fire && last_byte) state_nx = WRITE;
      WRITE:   state_nx = (words_left == (ADDR_W+1)'(1)) ? CHECK : RECV;
      CHECK:   if (byte_fire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst    <= 1'b0;
      imem_addr  <= '0;
      words_left <= '0;
    end else begin
      state      <= state_nx;
      byte_ready <= (state_nx == RECV) || (state_nx == CHECK);
      imem_we    <= (state_nx == WRITE);
      busy       <= (state_nx == RECV) || (state_nx == WRITE) || (state_nx == CHECK);
      done       <= (state_nx == DONE);

      if (start_ok) begin
        words_left <= len_words;
        imem_addr  <= '0;
        err        <= (len_words > DEPTH);
        cpu_rst    <= 1'b0;
      end

      if (state == WRITE) begin
        imem_addr  <= imem_addr + 1'b1;
        words_left <= words_left - 1'b1;
      end

      if (state == CHECK && byte_fire && byte_data != xor_acc)
        err <= 1'b1;

      if (state == DONE)
        cpu_rst <= ~err;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a queue-based model
// of the expected word writes, checksum outcome and datapath reset.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len_words = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fixed_bytes [8] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h22, 8'h18, 8'h20};

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // vmode: 0 always valid, 1 toggle every cycle, 2 random. abort_at>0 resets
  // the DUT once that many bytes have been accepted.
  task automatic run_load(input int unsigned len, input int unsigned vmode,
                          input bit bad_ck, input int unsigned abort_at, input bit use_fixed);
    logic [7:0]  stream [$];
    logic [31:0] exp_w [$];
    logic [7:0]  ck;
    logic [7:0]  b;
    logic [31:0] word;
    bit          legal, exp_err, fire_pending, seen_done;
    int unsigned idx, wr_n, cyc;

    legal = (len > 0) && (len <= DEPTH);
    ck = '0;
    if (legal) begin
      for (int unsigned w = 0; w < len; w++) begin
        word = '0;
        for (int unsigned k = 0; k < 4; k++) begin
          b = use_fixed ? fixed_bytes[(w*4 + k) % 8] : 8'($urandom);
          word = word * 256 + {24'd0, b};
          ck = ck ^ b;
          stream.push_back(b);
        end
        exp_w.push_back(word);
      end
      stream.push_back(bad_ck ? ck ^ 8'($urandom_range(1, 255)) : ck);
    end
    exp_err = legal ? bad_ck : (len > DEPTH);

    @(negedge clk);
    start = 1'b1;
    len_words = (ADDR_W+1)'(len);
    @(negedge clk);
    start = 1'b0;

    idx = 0; wr_n = 0; fire_pending = 0; seen_done = 0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      if (fire_pending) idx++;
      if (cyc == 0) check("cpu_rst_held", {31'd0, cpu_rst}, 32'd0);
      if (imem_we) begin
        check("wr_ready_low", {31'd0, byte_ready}, 32'd0);
        check("wr_count", wr_n + 1, (wr_n < exp_w.size()) ? wr_n + 1 : exp_w.size());
        if (wr_n < exp_w.size()) begin
          check("wr_addr", {24'd0, imem_addr}, wr_n);
          check("wr_data", imem_wdata, exp_w[wr_n]);
        end
        wr_n++;
      end else if (busy) begin
        check("recv_ready_high", {31'd0, byte_ready}, 32'd1);
      end
      if (abort_at != 0 && idx >= abort_at) break;
      if (done) begin
        seen_done = 1;
        break;
      end
      start = (vmode == 2 && legal && cyc == 3);
      case (vmode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = ~byte_valid;
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      if (idx >= stream.size()) byte_valid = 1'b0;
      byte_data = (idx < stream.size()) ? stream[idx] : 8'($urandom);
      fire_pending = byte_valid && byte_ready;
      @(negedge clk);
    end
    start = 1'b0;

    if (abort_at != 0) begin
      check("abort_reached", idx, abort_at);
      rst = 1'b0;
      byte_valid = 1'b0;
      #1;
      check("abort_writes", wr_n, abort_at / 4);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_ready", {31'd0, byte_ready}, 32'd0);
      check("abort_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_idle_we", {31'd0, imem_we}, 32'd0);
    end else begin
      check("done_seen", {31'd0, seen_done}, 32'd1);
      check("err", {31'd0, err}, {31'd0, exp_err});
      check("busy_in_done", {31'd0, busy}, 32'd0);
      check("writes", wr_n, exp_w.size());
      check("bytes_used", idx, stream.size());
      if (!legal) check("done_latency", cyc, 32'd0);
      byte_valid = 1'b0;
      if (vmode == 2) begin
        start = 1'b1;
        len_words = (ADDR_W+1)'(1);
      end
      @(negedge clk);
      start = 1'b0;
      check("cpu_rst", {31'd0, cpu_rst}, {31'd0, !exp_err});
      check("done_pulse", {31'd0, done}, 32'd0);
      check("start_in_done_ignored", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #1;
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, byte_ready}, 32'd0);

    run_load(2, 0, 1'b0, 0, 1'b1);
    run_load(2, 0, 1'b1, 0, 1'b1);
    run_load(2, 1, 1'b0, 0, 1'b1);
    run_load(0, 0, 1'b0, 0, 1'b0);
    run_load(DEPTH + 1, 0, 1'b0, 0, 1'b0);
    run_load(2, 1, 1'b0, 5, 1'b1);
    run_load(2, 0, 1'b0, 0, 1'b1);
    run_load(DEPTH, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 12; i++)
      run_load($urandom_range(1, 6), 2, 1'($urandom_range(0, 1)), 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
